// File: rtl/pipe_hazard_ctrl.sv
// Decode/execute hazard control: operand forwarding, load-use stall and
// a busy/latency sequencer for the multi-cycle multiply/divide unit.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [4:0]  drs,
  input  logic [4:0]  drt,
  input  logic        duse_rs,
  input  logic        duse_rt,
  input  logic        dmdu,
  input  logic        dhilo,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic [4:0]  ern,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic [4:0]  mrn,
  output logic        wpcir,
  output logic        bubble,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic        mdu_start,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic [31:0] stall_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MDU_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             lu, md, stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic ew, input logic em,
                                         input logic [4:0] en,
                                         input logic mw, input logic mm,
                                         input logic [4:0] mn);
    logic [1:0] sel;
    sel = 2'd0;
    // EX-stage load data is not available yet, so only ALU results bypass from EX
    if (ew && (en == src) && (en != 5'd0) && !em)
      sel = 2'd1;
    else if (mw && (mn == src) && (mn != 5'd0))
      sel = mm ? 2'd3 : 2'd2;
    return sel;
  endfunction

  always_comb begin
    fwda = fwd_sel(drs, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
    fwdb = fwd_sel(drt, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
  end

  assign lu = ewreg && em2reg && (ern != 5'd0) &&
              ((duse_rs && (ern == drs)) || (duse_rt && (ern == drt)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mdu_start = 1'b0;
    mdu_done  = 1'b0;
    md        = 1'b0;
    case (state_q)
      IDLE: begin
        if (dmdu && !lu) begin
          mdu_start = 1'b1;
          cnt_d     = CNT_RELOAD;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          md    = dmdu || dhilo;
        end else begin
          // HI/LO is bypassed on the final cycle, so dependents go through now
          mdu_done = 1'b1;
          if (dmdu && !lu) begin
            mdu_start = 1'b1;
            cnt_d     = CNT_RELOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall    = lu || md;
  assign wpcir    = !stall;
  assign bubble   = stall;
  assign mdu_busy = (state_q == BUSY);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
